// File: rtl/proc_b_pkg.sv
// Shared lane-B processor definitions.
// Holds the instruction-type codes handed from EX to MEM, the opcode
// constants shared with the ALU and decode, the destination-register
// field position, and the MEM-stage FSM state encoding.
package proc_b_pkg;

    // Instruction type carried alongside the ALU result.
    typedef enum logic [2:0] {
        RR_ALU = 3'b000,
        RI_ALU = 3'b001,
        LOAD   = 3'b010,
        STORE  = 3'b011,
        NOP    = 3'b111
    } itype_e;

    // Primary opcodes (in_ir[31:26]) shared with the ALU and decode.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Destination register field.
    localparam int RD_MSB = 25;
    localparam int RD_LSB = 21;

    // MEM-stage FSM states.
    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Data-memory request timeout counter.
// Counts enabled cycles since the last clear. expire is asserted
// combinationally during the enabled cycle that is the TIMEOUT-th one.
// Ports:
//   clk     in  rising-edge clock
//   clear   in  synchronous clear to zero (has priority over enable)
//   enable  in  count this cycle
//   expire  out this enabled cycle is the TIMEOUT-th since clear
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/mem_stage_b.sv
// Lane-B MEM stage.
// ALU-type results retire to writeback one cycle after acceptance.
// LOAD/STORE issue a single data-memory request (address = ALU result)
// and hold off upstream until ack, timeout abort, or reset.
// Handshakes:
//   upstream: an op is accepted on a rising edge where in_valid & in_ready;
//     in_ready is high only in IDLE, upstream holds inputs otherwise.
//   memory:   dmem_req stays high with stable addr/we/wdata until an edge
//     where dmem_ack=1 (dmem_rdata valid then) or the timeout expires;
//     dmem_ack while dmem_req=0 is ignored.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_type/in_ir/in_alu_out/in_store_d  EX result
//   dmem_req/we/addr/wdata/rdata/ack                       data memory
//   wb_valid/wb_we/wb_rd/wb_data                           writeback
//   mem_err                       1-cycle pulse: misaligned or timeout
module mem_stage_b
    import proc_b_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [31:0]       in_ir,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_store_d,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);
    mem_state_e state;
    logic       pend_load;
    logic [4:0] pend_rd;

    logic       accept;
    logic [4:0] in_rd;
    logic       aligned;
    logic       expire;
    logic       unused_ir;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign in_rd     = in_ir[RD_MSB:RD_LSB];
    assign aligned   = (in_alu_out[1:0] == 2'b00);
    assign unused_ir = ^{in_ir[31:RD_MSB+1], in_ir[RD_LSB-1:0]};

    // Counter runs only while waiting and not acked, so an ack on the
    // TIMEOUT-th cycle completes normally instead of aborting.
    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .clear  (rst || (state != MEM_WAIT)),
        .enable ((state == MEM_WAIT) && !dmem_ack),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_load  <= 1'b0;
            pend_rd    <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            mem_err    <= 1'b0;
        end else begin
            // Pulses default low; wb_rd/wb_data hold between retires.
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (in_type)
                            RR_ALU, RI_ALU: begin
                                wb_valid <= 1'b1;
                                wb_we    <= (in_rd != 5'd0);
                                wb_rd    <= in_rd;
                                wb_data  <= in_alu_out;
                            end
                            LOAD, STORE: begin
                                if (!aligned) begin
                                    wb_valid <= 1'b1;
                                    wb_rd    <= in_rd;
                                    wb_data  <= '0;
                                    mem_err  <= 1'b1;
                                end else begin
                                    state      <= MEM_WAIT;
                                    dmem_req   <= 1'b1;
                                    dmem_we    <= (in_type == STORE);
                                    dmem_addr  <= in_alu_out[ADDR_W-1:0];
                                    dmem_wdata <= in_store_d;
                                    pend_load  <= (in_type == LOAD);
                                    pend_rd    <= in_rd;
                                end
                            end
                            default: ; // NOP and unlisted codes are consumed silently
                        endcase
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_we    <= pend_load && (pend_rd != 5'd0);
                        wb_rd    <= pend_rd;
                        wb_data  <= pend_load ? dmem_rdata : '0;
                    end else if (expire) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_rd    <= pend_rd;
                        wb_data  <= '0;
                        mem_err  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_b.sv
module tb_mem_stage_b;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [31:0] in_ir;
    logic [31:0] in_alu_out;
    logic [31:0] in_store_d;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;

    int checks = 0;
    int failures = 0;

    mem_stage_b #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_ir      (in_ir),
        .in_alu_out (in_alu_out),
        .in_store_d (in_store_d),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .mem_err    (mem_err)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] make_ir(input logic [5:0] op, input logic [4:0] rd);
        make_ir = {op, rd, 21'h0};
    endfunction

    // Driver: present one op for a single accept edge, then drop valid.
    task automatic issue(input logic [2:0] t, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd);
        in_valid   = 1'b1;
        in_type    = t;
        in_ir      = make_ir(6'h08, rd);
        in_alu_out = alu;
        in_store_d = sd;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_type = 3'b111; in_ir = '0;
        in_alu_out = '0; in_store_d = '0; dmem_rdata = '0; dmem_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || dmem_req !== 1'b0 || wb_valid !== 1'b0 || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl got ready=%b req=%b wbv=%b err=%b exp 1 0 0 0",
                     in_ready, dmem_req, wb_valid, mem_err);
        end
        checks++;
        if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0 || dmem_we !== 1'b0 || dmem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got we=%b rd=%0d data=%h dwe=%b addr=%h exp all 0",
                     wb_we, wb_rd, wb_data, dmem_we, dmem_addr);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_type = 3'b001; in_ir = make_ir(6'h08, 5'd3); in_alu_out = 32'h0000_0010;
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h10 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL addi_wb got v=%b we=%b rd=%0d data=%h rdy=%b exp 1 1 3 00000010 1",
                     wb_valid, wb_we, wb_rd, wb_data, in_ready);
        end
        in_type = 3'b000; in_ir = make_ir(6'h00, 5'd0); in_alu_out = 32'h0000_0055;
        tick();
        in_valid = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h55 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_r0_wb got v=%b we=%b rd=%0d data=%h rdy=%b exp 1 0 0 00000055 1",
                     wb_valid, wb_we, wb_rd, wb_data, in_ready);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL wb_idle got %b exp 0", wb_valid);
        end
    endtask

    task automatic test_load();
        int bad;
        bad = 0;
        issue(3'b010, 5'd7, 32'h0000_0100, 32'h0);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100) begin
            failures++;
            $display("FAIL load_req got req=%b we=%b addr=%h exp 1 0 00000100", dmem_req, dmem_we, dmem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            if (dmem_req !== 1'b1 || in_ready !== 1'b0 || wb_valid !== 1'b0) bad++;
            if (i == 2) begin
                dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL load_wait got %0d bad cycles exp 0", bad);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'hDEAD_BEEF ||
            dmem_req !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_wb got v=%b we=%b rd=%0d data=%h req=%b rdy=%b exp 1 1 7 deadbeef 0 1",
                     wb_valid, wb_we, wb_rd, wb_data, dmem_req, in_ready);
        end
    endtask

    task automatic test_store();
        issue(3'b011, 5'd9, 32'h0000_0204, 32'h1234_5678);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h204 || dmem_wdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL store_req got req=%b we=%b addr=%h wdata=%h exp 1 1 00000204 12345678",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 32'h0 || dmem_req !== 1'b0 || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL store_wb got v=%b we=%b data=%h req=%b err=%b exp 1 0 0 0 0",
                     wb_valid, wb_we, wb_data, dmem_req, mem_err);
        end
    endtask

    task automatic test_misaligned();
        issue(3'b010, 5'd4, 32'h0000_0102, 32'h0);
        checks++;
        if (dmem_req !== 1'b0 || mem_err !== 1'b1 || wb_valid !== 1'b1 || wb_we !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL misaligned got req=%b err=%b v=%b we=%b rdy=%b exp 0 1 1 0 1",
                     dmem_req, mem_err, wb_valid, wb_we, in_ready);
        end
        tick();
        checks++;
        if (mem_err !== 1'b0 || wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse got err=%b v=%b exp 0 0", mem_err, wb_valid);
        end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        issue(3'b010, 5'd5, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 40 && dmem_req === 1'b1; i++) begin
            n++;
            tick();
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL timeout_len got %0d req cycles exp 16", n);
        end
        checks++;
        if (mem_err !== 1'b1 || wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_rd !== 5'd5 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_wb got err=%b v=%b we=%b rd=%0d rdy=%b exp 1 1 0 5 1",
                     mem_err, wb_valid, wb_we, wb_rd, in_ready);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        tick();
        dmem_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || mem_err !== 1'b0 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL stray_ack got v=%b err=%b req=%b exp 0 0 0", wb_valid, mem_err, dmem_req);
        end
        // Ack exactly on the 16th req cycle completes normally.
        issue(3'b010, 5'd6, 32'h0000_0400, 32'h0);
        n = 0;
        for (int i = 1; i <= 16; i++) begin
            if (dmem_req !== 1'b1) n++;
            if (i == 16) begin
                dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_0016;
            end
            tick();
        end
        dmem_ack = 1'b0;
        checks++;
        if (n != 0 || mem_err !== 1'b0 || wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd6 ||
            wb_data !== 32'hCAFE_0016) begin
            failures++;
            $display("FAIL ack_at_16 got drops=%0d err=%b v=%b we=%b rd=%0d data=%h exp 0 0 1 1 6 cafe0016",
                     n, mem_err, wb_valid, wb_we, wb_rd, wb_data);
        end
    endtask

    task automatic test_reset_mid();
        issue(3'b010, 5'd8, 32'h0000_0500, 32'h0);
        tick();
        checks++;
        if (dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_req got %b exp 1", dmem_req);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || mem_err !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got req=%b v=%b err=%b rdy=%b exp 0 0 0 1",
                     dmem_req, wb_valid, mem_err, in_ready);
        end
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL late_ack got v=%b err=%b exp 0 0", wb_valid, mem_err);
        end
    endtask

    task automatic test_nop();
        issue(3'b111, 5'd2, 32'h0000_0008, 32'h0);
        checks++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL nop got v=%b req=%b rdy=%b exp 0 0 1", wb_valid, dmem_req, in_ready);
        end
        issue(3'b101, 5'd2, 32'h0000_0008, 32'h0);
        checks++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL unlisted got v=%b req=%b err=%b exp 0 0 0", wb_valid, dmem_req, mem_err);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_nop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
